// File: rtl/uart_cmd_defs_pkg.sv
// Shared definitions for the UART command controller: command bytes,
// FSM state encoding and the default inter-byte timeout.
package uart_cmd_defs;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_LED   = 8'h4C;  // 'L'

  localparam int TIMEOUT_DEFAULT = 1200000;  // 100 ms at 12 MHz

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_ADDR  = 3'd1,
    ST_GET_DATA  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_READ_ADDR = 3'd4,
    ST_READ_WAIT = 3'd5,
    ST_SEND      = 3'd6
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte timeout counter: runs while enabled, clears on restart or
// when disabled, and flags expiry on the last cycle of the window.
module frame_timer #(
  parameter int CYCLES = 1200000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q + 1'b1;
    if (restart || !enable) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && !restart && (count_q == CNT_W'(CYCLES - 1));

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Byte-oriented command decoder: 'W' addr data writes RAM, 'R' addr reads
// RAM and echoes on tx, 'L' data loads the LED register.
module uart_cmd_ctrl
  import uart_cmd_defs::*;
#(
  parameter int         TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter logic [7:0] LED_RESET      = 8'h01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_wdata,
  output logic       ram_we,
  input  logic [7:0] ram_rdata,
  output logic [7:0] tx_data,
  output logic       tx_data_ready,
  input  logic       tx_busy,
  output logic [7:0] leds,
  output logic [7:0] err_count,
  output logic       busy
);

  state_t     state_q,    state_d;
  logic [7:0] cmd_q,      cmd_d;
  logic [7:0] addr_q,     addr_d;
  logic [7:0] data_q,     data_d;
  logic [7:0] tx_data_q,  tx_data_d;
  logic [7:0] leds_q,     leds_d;
  logic [7:0] err_q,      err_d;
  logic       led_pend_q, led_pend_d;
  logic       ram_we_q,   ram_we_d;

  logic accept;
  logic err_inc;
  logic timer_en;
  logic timer_expired;

  assign timer_en = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);

  frame_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_frame_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (accept),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tx_data_d  = tx_data_q;
    leds_d     = leds_q;
    led_pend_d = 1'b0;
    ram_we_d   = 1'b0;
    accept     = 1'b0;
    err_inc    = 1'b0;

    // LED load lands one cycle after the data byte so the path is fully registered.
    if (led_pend_q) begin
      leds_d = data_q;
    end

    if (rx_error) begin
      state_d = ST_IDLE;
      err_inc = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_valid) begin
            if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
              cmd_d   = rx_data;
              state_d = ST_GET_ADDR;
              accept  = 1'b1;
            end else if (rx_data == CMD_LED) begin
              cmd_d   = rx_data;
              state_d = ST_GET_DATA;
              accept  = 1'b1;
            end else begin
              err_inc = 1'b1;
            end
          end
        end
        ST_GET_ADDR: begin
          if (rx_valid) begin
            addr_d  = rx_data;
            accept  = 1'b1;
            state_d = (cmd_q == CMD_WRITE) ? ST_GET_DATA : ST_READ_ADDR;
          end else if (timer_expired) begin
            state_d = ST_IDLE;
            err_inc = 1'b1;
          end
        end
        ST_GET_DATA: begin
          if (rx_valid) begin
            data_d = rx_data;
            accept = 1'b1;
            if (cmd_q == CMD_WRITE) begin
              state_d  = ST_WRITE;
              ram_we_d = 1'b1;
            end else begin
              state_d    = ST_IDLE;
              led_pend_d = 1'b1;
            end
          end else if (timer_expired) begin
            state_d = ST_IDLE;
            err_inc = 1'b1;
          end
        end
        ST_WRITE: begin
          state_d = ST_IDLE;
          err_inc = rx_valid;
        end
        ST_READ_ADDR: begin
          state_d = ST_READ_WAIT;
          err_inc = rx_valid;
        end
        ST_READ_WAIT: begin
          tx_data_d = ram_rdata;
          state_d   = ST_SEND;
          err_inc   = rx_valid;
        end
        ST_SEND: begin
          if (!tx_busy) begin
            state_d = ST_IDLE;
          end
          err_inc = rx_valid;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    err_d = err_inc ? sat_inc8(err_q) : err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cmd_q      <= 8'h00;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      tx_data_q  <= 8'h00;
      leds_q     <= LED_RESET;
      err_q      <= 8'h00;
      led_pend_q <= 1'b0;
      ram_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tx_data_q  <= tx_data_d;
      leds_q     <= leds_d;
      err_q      <= err_d;
      led_pend_q <= led_pend_d;
      ram_we_q   <= ram_we_d;
    end
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = data_q;
  assign ram_we    = ram_we_q;
  assign tx_data   = tx_data_q;
  assign leds      = leds_q;
  assign err_count = err_q;
  assign busy      = (state_q != ST_IDLE);
  // Strobe fires in the very first SEND cycle that sees the transmitter idle.
  assign tx_data_ready = (state_q == ST_SEND) && !tx_busy;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl with a registered-read RAM
// model and pulse counters on ram_we / tx_data_ready.
module tb_uart_cmd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic [7:0] ram_rdata;
  logic [7:0] tx_data;
  logic       tx_data_ready;
  logic       tx_busy;
  logic [7:0] leds;
  logic [7:0] err_count;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int tx_cnt = 0;
  int tx_base;

  logic [7:0] mem [0:255];

  always #5 clk = ~clk;

  uart_cmd_ctrl #(
    .TIMEOUT_CYCLES (100),
    .LED_RESET      (8'h01)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_error      (rx_error),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_we        (ram_we),
    .ram_rdata     (ram_rdata),
    .tx_data       (tx_data),
    .tx_data_ready (tx_data_ready),
    .tx_busy       (tx_busy),
    .leds          (leds),
    .err_count     (err_count),
    .busy          (busy)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    if (ram_we) we_cnt <= we_cnt + 1;
    if (tx_data_ready) tx_cnt <= tx_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    ram_rdata = 8'h00;
    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_error = 1'b0; tx_busy = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_busy", busy, 1'b0);
    check("rst_leds", leds, 8'h01);
    check("rst_err", err_count, 8'h00);
    check("rst_addr", ram_addr, 8'h00);
    check("rst_txd", tx_data, 8'h00);

    // 'L' A5: leds change two cycles after the data byte
    send_byte(8'h4C);
    send_byte(8'hA5);
    check("led_lat1", leds, 8'h01);
    step();
    check("led_lat2", leds, 8'hA5);
    check("led_err", err_count, 8'h00);

    // 'W' 10 3C: ram_we one cycle after final byte
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'h3C);
    check("wr_we", ram_we, 1'b1);
    check("wr_addr", ram_addr, 8'h10);
    check("wr_data", ram_wdata, 8'h3C);
    step();
    check("wr_we_off", ram_we, 1'b0);
    check("wr_cnt", we_cnt, 1);

    // 'R' 10 with idle transmitter: strobe three cycles after addr byte
    send_byte(8'h52);
    send_byte(8'h10);
    check("rd_addr", ram_addr, 8'h10);
    check("rd_rdy_c1", tx_data_ready, 1'b0);
    step();
    check("rd_rdy_c2", tx_data_ready, 1'b0);
    step();
    check("rd_rdy_c3", tx_data_ready, 1'b1);
    check("rd_txd", tx_data, 8'h3C);
    step();
    check("rd_rdy_off", tx_data_ready, 1'b0);
    check("rd_idle", busy, 1'b0);
    check("rd_cnt", tx_cnt, 1);

    // 'R' 10 with transmitter busy for 50 cycles; a stray byte is dropped
    tx_busy = 1'b1;
    tx_base = tx_cnt;
    send_byte(8'h52);
    send_byte(8'h10);
    for (int i = 0; i < 25; i++) step();
    send_byte(8'h4C);
    check("drop_err", err_count, 8'h01);
    check("drop_busy", busy, 1'b1);
    for (int i = 0; i < 24; i++) step();
    check("busy_norm", tx_cnt, tx_base);
    tx_busy = 1'b0;
    #1;
    check("busy_rdy", tx_data_ready, 1'b1);
    check("busy_txd", tx_data, 8'h3C);
    step();
    check("busy_rdy_off", tx_data_ready, 1'b0);
    check("busy_cnt", tx_cnt, tx_base + 1);

    // 'W' 20 then silence: exactly 100 cycles in GET_DATA
    send_byte(8'h57);
    send_byte(8'h20);
    for (int i = 0; i < 99; i++) step();
    check("to_before", busy, 1'b1);
    step();
    check("to_after", busy, 1'b0);
    check("to_err", err_count, 8'h02);
    check("to_nowe", we_cnt, 1);

    // rx_error wins over simultaneous rx_valid
    send_byte(8'h57);
    rx_error = 1'b1;
    send_byte(8'h10);
    rx_error = 1'b0;
    check("rxe_idle", busy, 1'b0);
    check("rxe_err", err_count, 8'h03);
    send_byte(8'h4C);
    send_byte(8'h55);
    step();
    check("rxe_recover", leds, 8'h55);

    // 300 illegal bytes saturate the error counter
    for (int i = 0; i < 251; i++) send_byte(8'h00);
    check("sat_fe", err_count, 8'hFE);
    for (int i = 0; i < 49; i++) send_byte(8'h00);
    check("sat_ff", err_count, 8'hFF);

    // Reset mid-frame: no write, registers back to reset values
    send_byte(8'h57);
    send_byte(8'h01);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step(); step();
    check("mid_busy", busy, 1'b0);
    check("mid_leds", leds, 8'h01);
    check("mid_err", err_count, 8'h00);
    check("mid_wdata", ram_wdata, 8'h00);
    check("mid_nowe", we_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
